// File: rtl/mem_port_arbiter.sv
`default_nettype none
//============================================================================
// Module      : mem_port_arbiter
// Description : Shares one req/gnt/rvalid memory port between instruction
//               fetch (M0, read-only) and the load/store unit (M1). Keeps an
//               in-order FIFO of granted master IDs and steers each response
//               back to the master that issued the matching request.
// Revision    : 1.0 - initial release
//============================================================================
module mem_port_arbiter #(
    parameter int XLEN    = 32,
    parameter int MAX_OUT = 2,
    parameter int RR_MODE = 1
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            m0_req_i,
    input  logic [XLEN-1:0] m0_addr_i,
    output logic            m0_gnt_o,
    output logic            m0_rvalid_o,
    output logic [XLEN-1:0] m0_rdata_o,

    input  logic            m1_req_i,
    input  logic [XLEN-1:0] m1_addr_i,
    input  logic            m1_we_i,
    input  logic [3:0]      m1_be_i,
    input  logic [XLEN-1:0] m1_wdata_i,
    output logic            m1_gnt_o,
    output logic            m1_rvalid_o,
    output logic [XLEN-1:0] m1_rdata_o,

    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,

    output logic [2:0]      outstanding_o,
    output logic            err_o
);

    localparam int               PTR_W      = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [2:0]       c_max_cnt  = 3'(MAX_OUT);
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(MAX_OUT - 1);

    // Master IDs as stored in the FIFO and in the last-winner register
    typedef enum logic {
        ID_M0 = 1'b0,
        ID_M1 = 1'b1
    } id_t;

    logic [MAX_OUT-1:0] r_id_fifo;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [2:0]         r_count;
    id_t                r_last_winner;
    logic               r_err;

    id_t                w_sel;
    logic               w_space;
    logic               w_push;
    logic               w_pop;
    id_t                w_head;

    // Pick a master: a lone requester wins; on a tie either alternate or favour the LSU
    always_comb begin
        w_sel = ID_M0;
        if (m0_req_i && m1_req_i) begin
            if (RR_MODE != 0) begin
                w_sel = (r_last_winner == ID_M0) ? ID_M1 : ID_M0;
            end else begin
                w_sel = ID_M1;
            end
        end else if (m1_req_i) begin
            w_sel = ID_M1;
        end
    end

    // A response popping this cycle frees a slot for a request issued in the same cycle
    assign w_space   = (r_count < c_max_cnt) | mem_rvalid_i;
    assign mem_req_o = reset & (m0_req_i | m1_req_i) & w_space;

    // Drive the memory bus from the selected master; fetch is always a full-word read
    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (w_sel == ID_M1) begin
                mem_addr_o  = m1_addr_i;
                mem_we_o    = m1_we_i;
                mem_be_o    = m1_be_i;
                mem_wdata_o = m1_wdata_i;
            end else begin
                mem_addr_o  = m0_addr_i;
                mem_be_o    = 4'b1111;
            end
        end
    end

    assign w_push   = mem_req_o & mem_gnt_i;
    assign m0_gnt_o = w_push & (w_sel == ID_M0);
    assign m1_gnt_o = w_push & (w_sel == ID_M1);

    // Responses return in grant order, so the FIFO head names the owner
    assign w_pop       = reset & mem_rvalid_i & (r_count != 3'd0);
    assign w_head      = id_t'(r_id_fifo[r_rd_ptr]);
    assign m0_rvalid_o = w_pop & (w_head == ID_M0);
    assign m1_rvalid_o = w_pop & (w_head == ID_M1);
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;

    assign outstanding_o = r_count;
    assign err_o         = r_err;

    // ID FIFO, occupancy, arbitration history and sticky stray-response flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_id_fifo     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= 3'd0;
            r_last_winner <= ID_M1;
            r_err         <= 1'b0;
        end else begin
            if (w_push) begin
                r_id_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr            <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + PTR_W'(1);
                r_last_winner       <= w_sel;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (mem_rvalid_i && (r_count == 3'd0)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single instruction/data memory port between two requesters: instruction fetch (M0) and load/store unit (M1).
- Both masters and the memory use the same req/gnt/rvalid protocol.
- Tracks the master ID of every granted, outstanding request in an in-order ID FIFO, and routes each rvalid/rdata back to the master that issued it.
- Sits between the fetch/LSU stages and the memory model.

Parameters:
- XLEN, 32, address/data width (matches `size_X_LEN`).
- MAX_OUT, 2, maximum outstanding granted-but-unanswered requests (ID FIFO depth, 1..4).
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority with M1 (data) over M0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m0_req_i  in  1  fetch request
- m0_addr_i  in  XLEN  fetch address
- m0_gnt_o  out  1  fetch request accepted this cycle
- m0_rvalid_o  out  1  fetch response valid
- m0_rdata_o  out  XLEN  fetch response data
- m1_req_i  in  1  LSU request
- m1_addr_i  in  XLEN  LSU address
- m1_we_i  in  1  LSU write enable
- m1_be_i  in  4  LSU byte enables
- m1_wdata_i  in  XLEN  LSU write data
- m1_gnt_o  out  1  LSU request accepted
- m1_rvalid_o  out  1  LSU response valid
- m1_rdata_o  out  XLEN  LSU response data
- mem_req_o  out  1  memory request
- mem_addr_o  out  XLEN  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_wdata_o  out  XLEN  memory write data
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  XLEN  memory response data
- outstanding_o  out  3  current ID FIFO occupancy
- err_o  out  1  sticky flag: rvalid received with no outstanding request

Behaviour:
- Reset (reset=0, asynchronous):
  - ID FIFO empty; outstanding_o=0; err_o=0.
  - last_winner=M1, so M0 wins the first tie.
  - All gnt/rvalid outputs are 0 while reset is low.
  - Reset mid-transaction discards all outstanding IDs. Responses still in flight after reset release are unexpected and set err_o; the system must quiesce memory before reset.
- M0 is read-only:
  - mem_we_o=0, mem_be_o=4'b1111, mem_wdata_o=0 whenever M0 is selected.
- Space condition: space = (outstanding_o < MAX_OUT) | mem_rvalid_i. A same-cycle pop frees a slot.
- Selection (combinational, zero latency):
  - Only one master requesting: that master is selected.
  - Both requesting, RR_MODE=1: select the master that is not last_winner.
  - Both requesting, RR_MODE=0: select M1.
- Forwarding:
  - mem_req_o = selected master's req AND space.
  - mem_addr/we/be/wdata driven from the selected master; all zero (be=0) when mem_req_o=0.
  - No space: mem_req_o=0 and both gnt outputs are 0.
- Grant:
  - mX_gnt_o = mem_gnt_i AND mem_req_o AND (X selected). Same cycle as mem_gnt_i.
  - The non-selected master's gnt is 0; it must hold its request stable until granted.
- On a granted handshake (clock edge):
  - Push the selected ID into the FIFO.
  - last_winner <= selected ID.
  - last_winner updates only on a granted handshake, never on an ungranted request.
- Response path:
  - mem_rvalid_i with FIFO non-empty: pop the head; mX_rvalid_o=1 for X = head ID, same cycle (combinational).
  - mX_rdata_o = mem_rdata_i for both masters at all times; the data is qualified only by the matching rvalid.
  - mem_rvalid_i with FIFO empty: no rvalid output, and err_o <= 1 (sticky until reset).
- Simultaneous push and pop in one cycle: occupancy unchanged; FIFO order preserved. Pointers wrap modulo MAX_OUT.
- Responses return strictly in grant order; the memory is required to be in-order.
- No request is ever dropped or reordered. A request denied by arbitration or by mem_gnt_i=0 simply retries, and may be re-arbitrated the next cycle.

Test Plan:
1. Single fetch, no contention:
   - Stimulus: m0_req_i=1, m0_addr_i=0x100, mem_gnt_i=1; one cycle later mem_rvalid_i=1, mem_rdata_i=0x00000013.
   - Required: mem_addr_o=0x100 and m0_gnt_o=1 in cycle 0; outstanding_o=1; then m0_rvalid_o=1, m0_rdata_o=0x13, m1_rvalid_o=0.
2. Contention, RR_MODE=1:
   - Stimulus: both requesting every cycle (M0 0x200, M1 0x8000 write be=4'b0011); mem_gnt_i=1, responses one cycle later.
   - Required: grants alternate M0, M1, M0, M1 (M0 first after reset); mem_we_o=1 and mem_be_o=0011 only on M1 cycles.
3. Fixed priority, RR_MODE=0:
   - Stimulus: both masters requesting for 3 cycles.
   - Required: m1_gnt_o=1 all 3 cycles; m0_gnt_o=0; mem_addr_o=M1 address throughout.
4. Back-pressure at MAX_OUT=2:
   - Stimulus: grant 2 M0 requests with no rvalid.
   - Required: mem_req_o=0 and m0_gnt_o=0 on the third cycle.
   - Then mem_rvalid_i=1 with the request held: the third request is granted in that same cycle, and outstanding_o stays 2.
5. Out-of-band rvalid:
   - Stimulus: mem_rvalid_i=1 with the FIFO empty.
   - Required: no mX_rvalid_o asserted; err_o=1 and stays 1 until reset is pulsed low.
6. Async reset mid-operation:
   - Stimulus: assert reset=0 between clock edges with outstanding_o=2.
   - Required: outstanding_o=0 and gnt outputs 0 immediately, without waiting for a clock edge.
   - After release with a fresh request: grant order restarts at M0.
